sprite_anim_renderer: RTL and testbench

Parametrised animated-sprite pixel generator for the VGA pipeline. Given the current scan position and sprite origin, it addresses a multi-frame sprite ROM, applies integer power-of-two scaling and optional horizontal mirroring, and emits keyed RGB plus a pixel-valid flag to the layer compositor. An internal animation sequencer steps through frames on vertical-frame pulses, in looping or one-shot mode.

---
 rtl/sprite_anim_renderer.sv | 171 +++++++++++++++++
 tb/tb_sprite_anim_renderer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_renderer.sv
// Animated sprite pixel generator: hit test, ROM addressing,
// colour keying and a frame sequencer for looping/one-shot playback.
module sprite_anim_renderer #(
  parameter int SPRITE_W    = 70,
  parameter int SPRITE_H    = 81,
  parameter int SCALE_LOG2  = 1,
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_TICKS = 6,
  parameter int ADDR_W      = 15,
  parameter logic [3:0] KEY_R = 4'hF,
  parameter logic [3:0] KEY_G = 4'h0,
  parameter logic [3:0] KEY_B = 4'hF
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        SpriteX,
  input  logic [9:0]        SpriteY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              anim_start,
  input  logic              loop_mode,
  input  logic              flip,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [3:0]        rom_q,
  input  logic [3:0]        pal_r,
  input  logic [3:0]        pal_g,
  input  logic [3:0]        pal_b,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_on,
  output logic [3:0]        frame_idx,
  output logic              anim_done
);

  localparam logic [10:0] BOX_W = 11'(SPRITE_W << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(SPRITE_H << SCALE_LOG2);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPRITE_W * SPRITE_H);
  localparam logic [ADDR_W-1:0] ROW_SZ = ADDR_W'(SPRITE_W);
  localparam logic [9:0] LX_MAX = 10'(SPRITE_W - 1);
  localparam logic [5:0] TICK_LAST = 6'(FRAME_TICKS - 1);
  localparam logic [3:0] FRAME_LAST = 4'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [5:0]  tick, tick_n;
  logic [3:0]  frame_n;
  logic        valid1, valid2;
  logic        hit, opaque;
  logic [10:0] dx_e, dy_e, sx_e, sy_e;
  logic [9:0]  dx, dy, lx, ly, lx_f;
  logic [ADDR_W-1:0] addr;

  assign dx_e = {1'b0, DrawX};
  assign dy_e = {1'b0, DrawY};
  assign sx_e = {1'b0, SpriteX};
  assign sy_e = {1'b0, SpriteY};

  assign hit = (dx_e >= sx_e) && (dx_e < sx_e + BOX_W)
            && (dy_e >= sy_e) && (dy_e < sy_e + BOX_H);

  // offsets only matter on a hit, where they fit in 10 bits
  assign dx   = DrawX - SpriteX;
  assign dy   = DrawY - SpriteY;
  assign lx   = dx >> SCALE_LOG2;
  assign ly   = dy >> SCALE_LOG2;
  assign lx_f = flip ? (LX_MAX - lx) : lx;

  assign addr = ADDR_W'(frame_idx) * FRAME_SZ
              + ADDR_W'(ly) * ROW_SZ
              + ADDR_W'(lx_f);

  assign opaque = {pal_r, pal_g, pal_b} != {KEY_R, KEY_G, KEY_B};

  assign anim_done = (state == DONE);

  // stage 1 address register and the valid pipe alongside the ROM read
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      valid1      <= 1'b0;
      valid2      <= 1'b0;
    end else begin
      rom_address <= hit ? addr : '0;
      valid1      <= hit & blank;
      valid2      <= valid1;
    end
  end

  // output stage: keyed palette colour or black
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red       <= 4'h0;
      green     <= 4'h0;
      blue      <= 4'h0;
      sprite_on <= 1'b0;
    end else if (valid2 && opaque) begin
      red       <= pal_r;
      green     <= pal_g;
      blue      <= pal_b;
      sprite_on <= 1'b1;
    end else begin
      red       <= 4'h0;
      green     <= 4'h0;
      blue      <= 4'h0;
      sprite_on <= 1'b0;
    end
  end

  // sequencer state register
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tick      <= '0;
      frame_idx <= '0;
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      frame_idx <= frame_n;
    end
  end

  // sequencer next state; anim_start overrides everything
  always_comb begin
    state_n = state;
    tick_n  = tick;
    frame_n = frame_idx;
    if (anim_start) begin
      state_n = PLAY;
      tick_n  = '0;
      frame_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          frame_n = '0;
        end
        PLAY: begin
          if (frame_start) begin
            if (tick == TICK_LAST) begin
              tick_n = '0;
              if (frame_idx == FRAME_LAST) begin
                if (loop_mode) frame_n = '0;
                else           state_n = DONE;
              end else begin
                frame_n = frame_idx + 4'd1;
              end
            end else begin
              tick_n = tick + 6'd1;
            end
          end
        end
        DONE: begin
          frame_n = FRAME_LAST;
        end
        default: begin
          state_n = IDLE;
          tick_n  = '0;
          frame_n = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed bench for sprite_anim_renderer with a sync ROM model
// and a palette that can be forced to the transparent key.
module tb_sprite_anim_renderer;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, SpriteX, SpriteY;
  logic        blank, frame_start, anim_start, loop_mode, flip;
  logic [14:0] rom_address;
  logic [3:0]  rom_q;
  logic [3:0]  pal_r, pal_g, pal_b;
  logic [3:0]  red, green, blue;
  logic        sprite_on;
  logic [3:0]  frame_idx;
  logic        anim_done;
  logic        force_key;

  int errors = 0;
  int checks = 0;

  sprite_anim_renderer dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .SpriteX     (SpriteX),
    .SpriteY     (SpriteY),
    .blank       (blank),
    .frame_start (frame_start),
    .anim_start  (anim_start),
    .loop_mode   (loop_mode),
    .flip        (flip),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pal_r       (pal_r),
    .pal_g       (pal_g),
    .pal_b       (pal_b),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .sprite_on   (sprite_on),
    .frame_idx   (frame_idx),
    .anim_done   (anim_done)
  );

  always #5 vga_clk = ~vga_clk;

  // sync ROM: data is the low nibble of the address
  always @(posedge vga_clk) rom_q <= rom_address[3:0];

  assign pal_r = force_key ? 4'hF : rom_q;
  assign pal_g = force_key ? 4'h0 : 4'h1;
  assign pal_b = force_key ? 4'hF : 4'h2;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0;
    SpriteX = 10'd100; SpriteY = 10'd50;
    blank = 1'b1; frame_start = 1'b0; anim_start = 1'b0;
    loop_mode = 1'b1; flip = 1'b0; force_key = 1'b0;
    step(); step();
    chk("rst_addr", 32'(rom_address), 0);
    chk("rst_on", 32'(sprite_on), 0);
    chk("rst_frame", 32'(frame_idx), 0);
    chk("rst_done", 32'(anim_done), 0);
    reset_n = 1'b1;
    step();

    // addressing and 3-cycle latency
    DrawX = 10'd100; DrawY = 10'd50;
    step();
    chk("addr_origin", 32'(rom_address), 0);
    DrawX = 10'd103; DrawY = 10'd53;
    step();
    chk("addr_71", 32'(rom_address), 71);
    step();
    chk("on_origin", 32'(sprite_on), 1);
    chk("red_origin", 32'(red), 0);
    DrawX = 10'd240;
    step();
    chk("red_71", 32'(red), 7);
    chk("grn_71", 32'(green), 1);
    chk("blu_71", 32'(blue), 2);
    chk("addr_miss", 32'(rom_address), 0);
    step();
    chk("on_lag", 32'(sprite_on), 1);
    step();
    chk("on_miss", 32'(sprite_on), 0);
    chk("red_miss", 32'(red), 0);

    // mirrored addressing
    flip = 1'b1; DrawX = 10'd100; DrawY = 10'd50;
    step();
    chk("addr_flip", 32'(rom_address), 69);

    // looping animation
    loop_mode = 1'b1;
    anim_start = 1'b1;
    step();
    anim_start = 1'b0;
    chk("loop_f0", 32'(frame_idx), 0);
    pulses(6);
    chk("loop_f1", 32'(frame_idx), 1);
    pulses(6);
    chk("loop_f2", 32'(frame_idx), 2);
    step();
    chk("addr_flip_f2", 32'(rom_address), 11409);
    pulses(6);
    chk("loop_f3", 32'(frame_idx), 3);
    pulses(6);
    chk("loop_f0b", 32'(frame_idx), 0);
    chk("loop_done", 32'(anim_done), 0);

    // colour key and blanking
    flip = 1'b0; force_key = 1'b1;
    step(); step(); step(); step();
    chk("key_on", 32'(sprite_on), 0);
    chk("key_red", 32'(red), 0);
    force_key = 1'b0;
    step(); step(); step(); step();
    chk("opaque_on", 32'(sprite_on), 1);
    blank = 1'b0;
    step(); step(); step(); step();
    chk("blank_on", 32'(sprite_on), 0);
    blank = 1'b1;

    // one-shot animation
    loop_mode = 1'b0;
    anim_start = 1'b1;
    step();
    anim_start = 1'b0;
    pulses(18);
    chk("once_f3", 32'(frame_idx), 3);
    pulses(5);
    chk("once_notdone", 32'(anim_done), 0);
    pulses(1);
    chk("once_done", 32'(anim_done), 1);
    chk("once_f3b", 32'(frame_idx), 3);
    pulses(3);
    chk("done_hold", 32'(frame_idx), 3);

    // restart coincident with frame_start
    anim_start = 1'b1; frame_start = 1'b1;
    step();
    anim_start = 1'b0; frame_start = 1'b0;
    chk("restart_f", 32'(frame_idx), 0);
    chk("restart_done", 32'(anim_done), 0);
    pulses(5);
    chk("restart_tick", 32'(frame_idx), 0);
    pulses(1);
    chk("restart_adv", 32'(frame_idx), 1);

    // async reset with sprite visible, then IDLE ignores frame_start
    step(); step(); step();
    chk("pre_rst_on", 32'(sprite_on), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_on", 32'(sprite_on), 0);
    chk("arst_red", 32'(red), 0);
    chk("arst_addr", 32'(rom_address), 0);
    chk("arst_frame", 32'(frame_idx), 0);
    step();
    reset_n = 1'b1;
    pulses(7);
    chk("idle_frame", 32'(frame_idx), 0);
    chk("idle_done", 32'(anim_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
